// File: rtl/flag_pkg.sv
// Shared types and widths for the flag selector.
package flag_pkg;

  localparam int unsigned SEL_W = 8;

  typedef enum logic {
    DB_RELEASED = 1'b0,
    DB_PRESSED  = 1'b1
  } db_state_e;

endpackage : flag_pkg

// File: rtl/btn_debounce.sv
// Button conditioner: 2-FF synchroniser, frame-rate debounce FSM and a
// combinational press strobe that is valid on the deciding frame_start cycle.
module btn_debounce
  import flag_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_start_i,
  input  logic btn_i,
  output logic press_c_o
);

  localparam int unsigned CNT_W = (DEBOUNCE_FRAMES < 2) ? 1 : $clog2(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [1:0]       sync_q;
  logic             btn_s;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchroniser for the raw asynchronous button.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], btn_i};
    end
  end

  assign btn_s = sync_q[1];

  // Debounce state and stable-sample counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= DB_RELEASED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: count consecutive frame samples opposite to the accepted level.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (frame_start_i) begin
      case (state_q)
        DB_RELEASED: begin
          if (btn_s) begin
            if (cnt_q == CNT_LAST) begin
              state_d = DB_PRESSED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        DB_PRESSED: begin
          if (!btn_s) begin
            if (cnt_q == CNT_LAST) begin
              state_d = DB_RELEASED;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else begin
            cnt_d = '0;
          end
        end
        default: begin
          state_d = DB_RELEASED;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Press strobe on the frame_start cycle that accepts a new press.
  always_comb begin
    press_c_o = 1'b0;
    if (frame_start_i && (state_q == DB_RELEASED) && (state_d == DB_PRESSED)) begin
      press_c_o = 1'b1;
    end
  end

endmodule : btn_debounce

// File: rtl/flag_selector.sv
// Flag index selector: steps on debounced next/prev presses or an
// auto-advance timer, updating only on frame_start so a flag never
// changes mid-frame.
module flag_selector
  import flag_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 3,
  parameter int unsigned AUTO_FRAMES     = 180,
  parameter int unsigned TIMER_W         = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             auto_en,
  input  logic [SEL_W-1:0] count,
  output logic [SEL_W-1:0] selector,
  output logic             changed
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(AUTO_FRAMES - 1);

  logic               next_c, prev_c;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               changed_q, changed_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [SEL_W-1:0]   last_idx;
  logic [SEL_W-1:0]   sel_inc, sel_dec;
  logic               timer_due;
  logic               step_taken;

  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_next (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .btn_i         (btn_next),
    .press_c_o     (next_c)
  );

  btn_debounce #(.DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)) u_db_prev (
    .clk           (clk),
    .rst_n         (rst_n),
    .frame_start_i (frame_start),
    .btn_i         (btn_prev),
    .press_c_o     (prev_c)
  );

  // Wrapping neighbours of the current index; last_idx is only meaningful for count != 0.
  always_comb begin
    last_idx  = (count == '0) ? '0 : (count - SEL_W'(1));
    sel_inc   = (sel_q == last_idx) ? '0 : (sel_q + SEL_W'(1));
    sel_dec   = (sel_q == '0) ? last_idx : (sel_q - SEL_W'(1));
    timer_due = (timer_q == TIMER_LAST);
  end

  // Step priority, auto timer update and change detect, all gated by frame_start.
  always_comb begin
    sel_d      = sel_q;
    timer_d    = timer_q;
    step_taken = 1'b0;
    if (frame_start) begin
      if (count == '0) begin
        sel_d = '0;
      end else if (sel_q >= count) begin
        sel_d = '0;
      end else if (next_c && !prev_c) begin
        sel_d      = sel_inc;
        step_taken = 1'b1;
      end else if (prev_c && !next_c) begin
        sel_d      = sel_dec;
        step_taken = 1'b1;
      end else if (!next_c && !prev_c && auto_en && timer_due) begin
        sel_d      = sel_inc;
        step_taken = 1'b1;
      end
      // A pre-empted auto step also restarts the period, keeping the timer in range.
      if (step_taken || timer_due) begin
        timer_d = '0;
      end else begin
        timer_d = timer_q + TIMER_W'(1);
      end
    end
    if (!auto_en) begin
      timer_d = '0;
    end
    changed_d = frame_start && (sel_d != sel_q);
  end

  // Selector, change pulse and auto timer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q     <= '0;
      changed_q <= 1'b0;
      timer_q   <= '0;
    end else begin
      sel_q     <= sel_d;
      changed_q <= changed_d;
      timer_q   <= timer_d;
    end
  end

  assign selector = sel_q;
  assign changed  = changed_q;

endmodule : flag_selector

// File: tb/tb_flag_selector.sv
// Self-checking bench for flag_selector against a frame-level behavioural model.
module tb_flag_selector;

  localparam int unsigned DEB  = 3;
  localparam int unsigned AUTO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       frame_start;
  logic       btn_next;
  logic       btn_prev;
  logic       auto_en;
  logic [7:0] count;
  logic [7:0] selector;
  logic       changed;

  int n_vec = 0;
  int n_err = 0;

  // Model state: accepted button levels, runs of opposite samples, index, frames since last step.
  bit m_lvl [2];
  int m_run [2];
  int m_sel;
  int m_timer;
  bit m_chg;

  flag_selector #(
    .DEBOUNCE_FRAMES (DEB),
    .AUTO_FRAMES     (AUTO),
    .TIMER_W         (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .btn_next    (btn_next),
    .btn_prev    (btn_prev),
    .auto_en     (auto_en),
    .count       (count),
    .selector    (selector),
    .changed     (changed)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lvl[0] = 1'b0; m_lvl[1] = 1'b0;
    m_run[0] = 0;    m_run[1] = 0;
    m_sel    = 0;
    m_timer  = 0;
    m_chg    = 1'b0;
  endtask

  // One frame of behaviour: debounce samples, then the step rules in priority order.
  task automatic model_frame(input bit n, input bit p);
    bit lv [2];
    bit st [2];
    int cnt;
    int old;
    bit stepped;
    lv[0] = n; lv[1] = p;
    for (int b = 0; b < 2; b++) begin
      st[b] = 1'b0;
      if (lv[b] != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == int'(DEB)) begin
          m_lvl[b] = lv[b];
          m_run[b] = 0;
          st[b]    = lv[b];
        end
      end else begin
        m_run[b] = 0;
      end
    end
    cnt     = int'(count);
    old     = m_sel;
    stepped = 1'b0;
    if (cnt == 0 || m_sel >= cnt) m_sel = 0;
    else if (st[0] && st[1]) stepped = 1'b0;
    else if (st[0]) begin m_sel = (m_sel + 1) % cnt; stepped = 1'b1; end
    else if (st[1]) begin m_sel = (m_sel + cnt - 1) % cnt; stepped = 1'b1; end
    else if (auto_en && m_timer == int'(AUTO) - 1) begin m_sel = (m_sel + 1) % cnt; stepped = 1'b1; end
    if (!auto_en || stepped || m_timer == int'(AUTO) - 1) m_timer = 0;
    else m_timer++;
    m_chg = (m_sel != old);
  endtask

  // Drive one frame: buttons settle through the synchroniser, then a frame_start pulse.
  task automatic frame(input bit n, input bit p);
    @(negedge clk);
    btn_next = n;
    btn_prev = p;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_vec++;
      if (selector !== 8'(m_sel) || changed !== 1'b0) begin
        n_err++;
        $display("FAIL idle: selector=%0d changed=%b, expected selector=%0d changed=0",
                 selector, changed, m_sel);
      end
    end
    frame_start = 1'b1;
    model_frame(n, p);
    @(negedge clk);
    frame_start = 1'b0;
    n_vec++;
    if (selector !== 8'(m_sel) || changed !== m_chg) begin
      n_err++;
      $display("FAIL frame: selector=%0d changed=%b, expected selector=%0d changed=%b",
               selector, changed, m_sel, m_chg);
    end
  endtask

  task automatic press(input bit is_next);
    for (int i = 0; i < 3; i++) frame(is_next, !is_next);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_vec++;
    if (selector !== 8'd0 || changed !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: selector=%0d changed=%b, expected 0/0", selector, changed);
    end
    count = 8'd8;
    press(1'b0);
    n_vec++;
    if (selector !== 8'd7) begin
      n_err++;
      $display("FAIL reset_setup: selector=%0d, expected 7", selector);
    end
    // Asynchronous reset between frames, checked before the next clock edge.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    n_vec++;
    if (selector !== 8'd0 || changed !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: selector=%0d changed=%b, expected 0/0", selector, changed);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Reset in the middle of a debounce run discards the partial count.
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    frame(1'b1, 1'b0);
    n_vec++;
    if (selector !== 8'd0) begin
      n_err++;
      $display("FAIL reset_debounce: selector=%0d, expected 0", selector);
    end
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    n_vec++;
    if (selector !== 8'd1) begin
      n_err++;
      $display("FAIL reset_repress: selector=%0d, expected 1", selector);
    end
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);
  endtask

  task automatic test_press();
    apply_reset();
    count = 8'd45;
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    frame(1'b1, 1'b0);
    n_vec++;
    if (selector !== 8'd1 || changed !== 1'b1) begin
      n_err++;
      $display("FAIL press_step: selector=%0d changed=%b, expected 1/1", selector, changed);
    end
    for (int i = 0; i < 100; i++) frame(1'b1, 1'b0);
    n_vec++;
    if (selector !== 8'd1) begin
      n_err++;
      $display("FAIL press_hold: selector=%0d, expected 1", selector);
    end
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);
  endtask

  task automatic test_wrap();
    apply_reset();
    count = 8'd45;
    press(1'b0);
    n_vec++;
    if (selector !== 8'd44) begin
      n_err++;
      $display("FAIL wrap_prev0: selector=%0d, expected 44", selector);
    end
    press(1'b1);
    n_vec++;
    if (selector !== 8'd0) begin
      n_err++;
      $display("FAIL wrap_next: selector=%0d, expected 0", selector);
    end
    press(1'b0);
    n_vec++;
    if (selector !== 8'd44) begin
      n_err++;
      $display("FAIL wrap_prev: selector=%0d, expected 44", selector);
    end
  endtask

  task automatic test_bounce();
    for (int f = 0; f < 20; f++) frame(((f / 2) % 2) == 0, 1'b0);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);
    n_vec++;
    if (selector !== 8'd44) begin
      n_err++;
      $display("FAIL bounce: selector=%0d, expected 44", selector);
    end
  endtask

  task automatic test_auto();
    apply_reset();
    count   = 8'd45;
    auto_en = 1'b1;
    for (int i = 0; i < 12; i++) frame(1'b0, 1'b0);
    n_vec++;
    if (selector !== 8'd3) begin
      n_err++;
      $display("FAIL auto_run: selector=%0d, expected 3", selector);
    end
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0);
    n_vec++;
    if (selector !== 8'd4) begin
      n_err++;
      $display("FAIL auto_manual: selector=%0d, expected 4", selector);
    end
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);
    n_vec++;
    if (selector !== 8'd4) begin
      n_err++;
      $display("FAIL auto_restart: selector=%0d, expected 4", selector);
    end
    frame(1'b0, 1'b0);
    n_vec++;
    if (selector !== 8'd5) begin
      n_err++;
      $display("FAIL auto_next: selector=%0d, expected 5", selector);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_limits();
    apply_reset();
    count = 8'd21;
    press(1'b0);
    count = 8'd10;
    frame(1'b0, 1'b0);
    n_vec++;
    if (selector !== 8'd0) begin
      n_err++;
      $display("FAIL limit_shrink: selector=%0d, expected 0", selector);
    end
    count = 8'd0;
    press(1'b1);
    press(1'b0);
    n_vec++;
    if (selector !== 8'd0) begin
      n_err++;
      $display("FAIL limit_zero: selector=%0d, expected 0", selector);
    end
    count = 8'd45;
    press(1'b1);
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) frame(1'b0, 1'b0);
    n_vec++;
    if (selector !== 8'd1) begin
      n_err++;
      $display("FAIL limit_both: selector=%0d, expected 1", selector);
    end
    count = 8'd1;
    frame(1'b0, 1'b0);
    press(1'b1);
    n_vec++;
    if (selector !== 8'd0) begin
      n_err++;
      $display("FAIL limit_one: selector=%0d, expected 0", selector);
    end
  endtask

  task automatic test_random();
    bit n, p;
    n = 1'b0;
    p = 1'b0;
    apply_reset();
    count = 8'd30;
    for (int f = 0; f < 300; f++) begin
      if ($urandom_range(0, 3) == 0) n = !n;
      if ($urandom_range(0, 4) == 0) p = !p;
      if ($urandom_range(0, 19) == 0) count = 8'($urandom_range(0, 50));
      if ($urandom_range(0, 19) == 0) auto_en = !auto_en;
      frame(n, p);
    end
    auto_en = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    frame_start = 1'b0;
    btn_next    = 1'b0;
    btn_prev    = 1'b0;
    auto_en     = 1'b0;
    count       = 8'd0;
    model_reset();
    test_reset();
    test_press();
    test_wrap();
    test_bounce();
    test_auto();
    test_limits();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_flag_selector
